// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS main control FSM:
// state encodings, instruction classes, opcode/funct codes and
// the ALU-select and PC-source codes driven to the datapath.
package mips_multicycle_ctrl_pkg;

  localparam int ST_W = 3;

  // Register-/immediate-type execution share one EXEC state, and branches
  // and jumps share one XFER state; the IR class picks the behaviour, which
  // keeps the state register at three bits.
  typedef enum logic [ST_W-1:0] {
    ST_FETCH    = 3'd0,
    ST_DECODE   = 3'd1,
    ST_EXEC     = 3'd2,
    ST_EXEC_MEM = 3'd3,
    ST_MEM      = 3'd4,
    ST_WB       = 3'd5,
    ST_XFER     = 3'd6,
    ST_HALT     = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    CLS_ILLEGAL = 3'd0,
    CLS_RTYPE   = 3'd1,
    CLS_IMM     = 3'd2,
    CLS_LOAD    = 3'd3,
    CLS_STORE   = 3'd4,
    CLS_BRANCH  = 3'd5,
    CLS_JUMP    = 3'd6,
    CLS_HALT    = 3'd7
  } instr_class_e;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  // R-type functs that use signed arithmetic (IR[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operation select seen by alu_ctrl
  localparam logic [1:0] ALU_OP_RI  = 2'b00;
  localparam logic [1:0] ALU_OP_ADD = 2'b01;
  localparam logic [1:0] ALU_OP_SUB = 2'b10;

  // PC source select
  localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  // Signed R-type arithmetic: ADD, SUB and SLT only (ADDU/SUBU/SLTU are not).
  function automatic logic funct_is_signed(input logic [5:0] funct);
    return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_SLT);
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_decoder.sv
// Combinational instruction classifier: maps the IR opcode/funct fields to an
// instruction class plus the signed/immediate flags for the ALU control.
module mips_opcode_decoder
  import mips_multicycle_ctrl_pkg::*;
#(
  parameter int NB_CTRL_OPCODE = 6
) (
  input  logic [NB_CTRL_OPCODE-1:0] opcode_i,
  input  logic [NB_CTRL_OPCODE-1:0] funct_i,
  output instr_class_e              class_o,
  output logic                      signed_o,
  output logic                      imm_o,
  output logic                      link_o,
  output logic                      bne_o
);

  // Opcode lookup; anything not listed is reported as illegal.
  always_comb begin
    class_o  = CLS_ILLEGAL;
    signed_o = 1'b0;
    imm_o    = 1'b0;
    link_o   = 1'b0;
    bne_o    = 1'b0;
    case (opcode_i)
      OP_RTYPE: begin
        class_o  = CLS_RTYPE;
        signed_o = funct_is_signed(funct_i);
      end
      OP_ADDI, OP_SLTI: begin
        class_o  = CLS_IMM;
        signed_o = 1'b1;
        imm_o    = 1'b1;
      end
      OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        class_o = CLS_IMM;
        imm_o   = 1'b1;
      end
      OP_LW: begin
        class_o = CLS_LOAD;
        imm_o   = 1'b1;
      end
      OP_SW: begin
        class_o = CLS_STORE;
        imm_o   = 1'b1;
      end
      OP_BEQ: class_o = CLS_BRANCH;
      OP_BNE: begin
        class_o = CLS_BRANCH;
        bne_o   = 1'b1;
      end
      OP_J:   class_o = CLS_JUMP;
      OP_JAL: begin
        class_o = CLS_JUMP;
        link_o  = 1'b1;
      end
      OP_HALT: class_o = CLS_HALT;
      default: class_o = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main control: latches the fetched instruction into the IR
// and walks it through fetch/decode/execute/memory/writeback, driving the ALU
// control interface and datapath enables. Outputs are decoded from state and
// IR; only the branch PC strobe, the fetch PC strobe and the store-retire
// pulse also look at the current-cycle handshake/zero inputs.
module mips_multicycle_ctrl
  import mips_multicycle_ctrl_pkg::*;
#(
  parameter int NB_DATA        = 32,
  parameter int NB_CTRL_OPCODE = 6,
  parameter int NB_ALU_OP_SEL  = 2,
  parameter int NB_STATE       = 3
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic [NB_DATA-1:0]       i_instruction,
  input  logic                     i_fetch_valid,
  input  logic                     i_mem_ready,
  input  logic                     i_alu_zero,
  output logic                     o_fetch_req,
  output logic [NB_DATA-1:0]       o_instruction,
  output logic [NB_ALU_OP_SEL-1:0] o_alu_operation,
  output logic                     o_signed_operation,
  output logic                     o_inmediate_operation,
  output logic                     o_pc_write,
  output logic [1:0]               o_pc_src,
  output logic                     o_reg_write,
  output logic                     o_reg_dst,
  output logic                     o_mem_to_reg,
  output logic                     o_link,
  output logic                     o_mem_read,
  output logic                     o_mem_write,
  output logic                     o_instr_done,
  output logic                     o_illegal,
  output logic                     o_halted
);

  logic [NB_STATE-1:0] state_q;
  logic [NB_STATE-1:0] state_d;
  logic [NB_DATA-1:0]  ir_q;
  logic                load_ir;
  logic                br_taken;

  instr_class_e dec_class;
  logic         dec_signed;
  logic         dec_imm;
  logic         dec_link;
  logic         dec_bne;

  mips_opcode_decoder #(
    .NB_CTRL_OPCODE (NB_CTRL_OPCODE)
  ) u_decoder (
    .opcode_i (ir_q[NB_DATA-1 -: NB_CTRL_OPCODE]),
    .funct_i  (ir_q[NB_CTRL_OPCODE-1:0]),
    .class_o  (dec_class),
    .signed_o (dec_signed),
    .imm_o    (dec_imm),
    .link_o   (dec_link),
    .bne_o    (dec_bne)
  );

  assign load_ir       = (state_q == ST_FETCH) && i_fetch_valid;
  assign br_taken      = dec_bne ? ~i_alu_zero : i_alu_zero;
  assign o_instruction = ir_q;

  // State register and IR; reset aborts any instruction in flight.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_FETCH;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      if (load_ir) begin
        ir_q <= i_instruction;
      end
    end
  end

  // Next-state sequencing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: begin
        if (i_fetch_valid) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        case (dec_class)
          CLS_RTYPE, CLS_IMM:   state_d = ST_EXEC;
          CLS_LOAD, CLS_STORE:  state_d = ST_EXEC_MEM;
          CLS_BRANCH, CLS_JUMP: state_d = ST_XFER;
          CLS_HALT:             state_d = ST_HALT;
          default:              state_d = ST_FETCH;
        endcase
      end
      ST_EXEC:     state_d = ST_WB;
      ST_EXEC_MEM: state_d = ST_MEM;
      ST_MEM: begin
        if (i_mem_ready) begin
          state_d = (dec_class == CLS_LOAD) ? ST_WB : ST_FETCH;
        end
      end
      ST_WB:   state_d = ST_FETCH;
      ST_XFER: state_d = ST_FETCH;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  // Output decode; everything is held at zero while reset is asserted.
  always_comb begin
    o_fetch_req           = 1'b0;
    o_pc_write            = 1'b0;
    o_pc_src              = PC_SRC_SEQ;
    o_alu_operation       = ALU_OP_RI;
    o_signed_operation    = 1'b0;
    o_inmediate_operation = 1'b0;
    o_reg_write           = 1'b0;
    o_reg_dst             = 1'b0;
    o_mem_to_reg          = 1'b0;
    o_link                = 1'b0;
    o_mem_read            = 1'b0;
    o_mem_write           = 1'b0;
    o_instr_done          = 1'b0;
    o_illegal             = 1'b0;
    o_halted              = 1'b0;
    if (i_reset) begin
      case (state_q)
        ST_FETCH: begin
          o_fetch_req = 1'b1;
          o_pc_write  = i_fetch_valid;
          o_pc_src    = PC_SRC_SEQ;
        end
        ST_DECODE: begin
          o_illegal = (dec_class == CLS_ILLEGAL);
        end
        ST_EXEC: begin
          o_alu_operation       = ALU_OP_RI;
          o_signed_operation    = dec_signed;
          o_inmediate_operation = dec_imm;
        end
        ST_EXEC_MEM: begin
          o_alu_operation       = ALU_OP_ADD;
          o_inmediate_operation = 1'b1;
        end
        ST_MEM: begin
          // Address stays driven through the ALU until memory answers.
          o_alu_operation       = ALU_OP_ADD;
          o_inmediate_operation = 1'b1;
          o_mem_read            = (dec_class == CLS_LOAD);
          o_mem_write           = (dec_class == CLS_STORE);
          o_instr_done          = (dec_class == CLS_STORE) && i_mem_ready;
        end
        ST_WB: begin
          o_reg_write  = 1'b1;
          o_reg_dst    = (dec_class == CLS_RTYPE);
          o_mem_to_reg = (dec_class == CLS_LOAD);
          o_instr_done = 1'b1;
        end
        ST_XFER: begin
          o_instr_done = 1'b1;
          if (dec_class == CLS_BRANCH) begin
            o_alu_operation = ALU_OP_SUB;
            o_pc_write      = br_taken;
            o_pc_src        = br_taken ? PC_SRC_BRANCH : PC_SRC_SEQ;
          end else begin
            o_pc_write  = 1'b1;
            o_pc_src    = PC_SRC_JUMP;
            o_reg_write = dec_link;
            o_link      = dec_link;
          end
        end
        ST_HALT: begin
          o_halted = 1'b1;
        end
        default: begin
          o_fetch_req = 1'b0;
        end
      endcase
    end
  end

endmodule
